gp_reg_bank: RTL

- Parametrised general-purpose register bank; successor to the per-bit single-register GP slice.
- NUM_REGS registers, each BUS_WIDTH+1 bits wide, behind an address decoder.
- Each register is individually typed as RW, RO (hardware-captured) or W1C (sticky status).
- Registered readback with a valid strobe; sits between the host bus interface and the datapath control/status bits.

---
 rtl/gp_reg_bank.sv | 114 +++++++++++
 1 files changed

// File: rtl/gp_reg_bank.sv
// Parametrised register bank with RW / RO (hardware-captured) / W1C (sticky) registers and registered readback.
// Optional even-parity protection with error injection is enabled by defining GP_REG_PARITY_EN.
module gp_reg_bank #(
   parameter int                    BUS_WIDTH = 15,
   parameter int                    NUM_REGS  = 4,
   parameter int                    ADDR_W    = 2,
   parameter logic [NUM_REGS-1:0]   RO_MASK   = '0,
   parameter logic [NUM_REGS-1:0]   W1C_MASK  = '0,
   parameter logic [BUS_WIDTH:0]    RESET_VAL = '0
) (
   input  logic                               sysclk,
   input  logic                               reset,
   input  logic                               wrb,
   input  logic                               rdb,
   input  logic [ADDR_W-1:0]                  addr,
   input  logic [BUS_WIDTH:0]                 din,
   input  logic [NUM_REGS*(BUS_WIDTH+1)-1:0]  hw_in,
`ifdef GP_REG_PARITY_EN
   input  logic                               par_inj,
   output logic                               par_err,
`endif
   output logic [BUS_WIDTH:0]                 rdout,
   output logic                               rd_valid,
   output logic                               addr_err,
   output logic [NUM_REGS*(BUS_WIDTH+1)-1:0]  reg_out
);

   localparam int          W       = BUS_WIDTH + 1;
   localparam int unsigned NREGS_U = NUM_REGS;

   logic [W-1:0] r_regs [NUM_REGS];
   logic [W-1:0] w_next [NUM_REGS];
   logic [W-1:0] w_rd_data;
   logic [W-1:0] r_rdout;
   logic         r_rd_valid;
   logic         r_addr_err;
   logic         w_in_range;
   logic         w_wr;
   logic         w_sel;
`ifdef GP_REG_PARITY_EN
   logic         r_par [NUM_REGS];
   logic         w_par_next [NUM_REGS];
   logic         w_rd_par;
   logic         r_par_err;
`endif

   assign w_in_range = 32'(addr) < NREGS_U;
   assign w_wr       = !wrb && w_in_range;

   always_comb begin
      w_next    = r_regs;
      w_rd_data = '0;
      w_sel     = 1'b0;
      reg_out   = '0;
`ifdef GP_REG_PARITY_EN
      w_par_next = r_par;
      w_rd_par   = 1'b0;
`endif
      for (int unsigned i = 0; i < NREGS_U; i++) begin
         w_sel = w_wr && (32'(addr) == i);
         if (32'(addr) == i) w_rd_data = r_regs[i];
         // a hardware set bit is OR-ed in last so it wins over a same-cycle clear
         if (RO_MASK[i])
            w_next[i] = hw_in[i*W +: W];
         else if (W1C_MASK[i])
            w_next[i] = (w_sel ? (r_regs[i] & ~din) : r_regs[i]) | hw_in[i*W +: W];
         else if (w_sel)
            w_next[i] = din;
         reg_out[i*W +: W] = r_regs[i];
`ifdef GP_REG_PARITY_EN
         if (32'(addr) == i) w_rd_par = r_par[i];
         // RW registers only update on a write; RO/W1C update every cycle
         if (RO_MASK[i])
            w_par_next[i] = ^w_next[i];
         else if (W1C_MASK[i] || w_sel)
            w_par_next[i] = (^w_next[i]) ^ (par_inj && w_sel);
`endif
      end
   end

   always_ff @(posedge sysclk) begin
      if (!reset) begin
         for (int unsigned i = 0; i < NREGS_U; i++) begin
            r_regs[i] <= (RO_MASK[i] || W1C_MASK[i]) ? '0 : RESET_VAL;
`ifdef GP_REG_PARITY_EN
            r_par[i]  <= (RO_MASK[i] || W1C_MASK[i]) ? 1'b0 : ^RESET_VAL;
`endif
         end
         r_rdout    <= '0;
         r_rd_valid <= 1'b0;
         r_addr_err <= 1'b0;
`ifdef GP_REG_PARITY_EN
         r_par_err  <= 1'b0;
`endif
      end else begin
         r_regs     <= w_next;
         r_rd_valid <= !rdb;
         r_addr_err <= (!rdb || !wrb) && !w_in_range;
         if (!rdb) r_rdout <= w_in_range ? w_rd_data : '0;
`ifdef GP_REG_PARITY_EN
         r_par      <= w_par_next;
         r_par_err  <= !rdb && w_in_range && ((^w_rd_data) != w_rd_par);
`endif
      end
   end

   assign rdout    = r_rdout;
   assign rd_valid = r_rd_valid;
   assign addr_err = r_addr_err;
`ifdef GP_REG_PARITY_EN
   assign par_err  = r_par_err;
`endif

endmodule
